// File: rtl/mem_if_pkg.sv
// Shared types and constants for the data-memory request/response interface.
// Used by the memory-side responder and by the core-side initiator.
package mem_if_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned STRB_W         = 4;
  localparam int unsigned LAT_CNT_W      = 4;
  localparam int unsigned REQ_ADDR_W     = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } memState_t;

  typedef struct packed {
    logic                  write;
    logic [REQ_ADDR_W-1:0] addr;
    logic [WORD_W-1:0]     wdata;
    logic [STRB_W-1:0]     wstrb;
  } memReq_t;

  typedef struct packed {
    logic [WORD_W-1:0] rdata;
    logic              err;
  } memRsp_t;

endpackage

// File: rtl/mem_word_array.sv
// Word-organised storage with byte-lane write enables and a combinational read port.
// Contents are never cleared; writes happen only when the access enable is high.
module mem_word_array
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts one load/store at a time, waits a programmable
// latency, performs the access on the word array and returns the result.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  memState_t             state, nextState;
  logic [LAT_CNT_W-1:0]  cnt;
  logic                  curWrite;
  logic [ADDR_W-1:0]     curAddr;
  logic [WORD_W-1:0]     curWdata;
  logic [STRB_W-1:0]     curWstrb;
  memRsp_t               rspReg;
  logic                  accept;
  logic                  access;
  logic                  addrErr;
  logic [WORD_W-1:0]     arrRdata;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  // Gating with reset guarantees an abandoned store is never written.
  assign access    = (state == WAIT) && (cnt == LAT_CNT_W'(1)) && !reset;
  assign addrErr   = (curAddr[1:0] != 2'b00) || ((curAddr >> 2) >= ADDR_W'(DEPTH_WORDS));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = WAIT;
      WAIT:    if (cnt == LAT_CNT_W'(1)) nextState = RESP;
      RESP:    if (rsp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      curWrite <= req_write;
      curAddr  <= req_addr;
      curWdata <= req_wdata;
      curWstrb <= req_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      rspReg <= '0;
    end else begin
      if (accept)             cnt <= LAT_CNT_W'(LATENCY);
      else if (state == WAIT) cnt <= cnt - 1'b1;
      if (access) begin
        rspReg.err   <= addrErr;
        rspReg.rdata <= (addrErr || curWrite) ? '0 : arrRdata;
      end
    end
  end

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) uArray (
    .clk   (clk),
    .en    (access && !addrErr),
    .we    (curWrite),
    .idx   (curAddr[IDX_W+1:2]),
    .wstrb (curWstrb),
    .wdata (curWdata),
    .rdata (arrRdata)
  );

  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rspReg.rdata;
  assign rsp_err   = rspReg.err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: requests push expected responses
// computed from a word-array reference model; a monitor pops and compares.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT),
    .ADDR_W      (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acceptEdge;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] refMem [DEPTH];
  int          acceptLog[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lastHsEdge = -100;
  bit          readyMode = 1'b0;
  logic        readyVal = 1'b1;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(negedge clk);
    rsp_ready = readyMode ? 1'($urandom_range(0, 1)) : readyVal;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(bit write, logic [31:0] addr, logic [31:0] wdata, logic [3:0] wstrb);
    exp_t e;
    int unsigned word = addr / 4;
    e.err = ((addr % 4) != 0) || (word >= DEPTH);
    e.rdata = '0;
    e.acceptEdge = 0;
    if (!e.err) begin
      if (write) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) refMem[word][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        e.rdata = refMem[word];
      end
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic doReq(bit write, logic [31:0] addr, logic [31:0] wdata, logic [3:0] wstrb,
                       bit keep, bit abort, bit afterHs);
    bit   got = 1'b0;
    exp_t e;
    req_valid = 1'b1;
    req_write = write;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    for (int n = 0; n < 300 && !got; n++) begin
      if (req_ready === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    if (got) begin
      acceptLog.push_back(cyc + 1);
      if (afterHs) check("accept_after_handshake", cyc + 1, lastHsEdge + 1);
      if (!abort) begin
        e = model(write, addr, wdata, wstrb);
        e.acceptEdge = cyc + 1;
        expQ.push_back(e);
      end
    end else begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no req_ready required req_ready=1 addr %h", addr);
    end
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    for (int n = 0; n < 600 && (expQ.size() != 0 || req_ready !== 1'b1); n++) @(negedge clk);
    if (expQ.size() != 0 || req_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got pending=%0d required pending=0", expQ.size());
    end
  endtask

  // Monitor: latency on rise, stability while stalled, data at each handshake.
  initial begin
    logic        pv = 1'b0;
    logic        ph = 1'b0;
    logic [31:0] pd = '0;
    logic        pe = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        pv = 1'b0;
        ph = 1'b0;
      end else begin
        if (rsp_valid && !pv) begin
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_response: got rsp_valid=1 required no response");
          end else begin
            check("rise_latency", cyc, expQ[0].acceptEdge + LAT);
          end
        end
        if (rsp_valid && pv && !ph) begin
          check("stable_rdata", rsp_rdata, pd);
          check("stable_err", 32'(rsp_err), 32'(pe));
        end
        if (rsp_valid && rsp_ready && expQ.size() != 0) begin
          e = expQ.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          lastHsEdge = cyc + 1;
        end
        pv = rsp_valid;
        ph = rsp_valid && rsp_ready;
        pd = rsp_rdata;
        pe = rsp_err;
      end
    end
  end

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b0;
    #1 check("post_reset_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    // Full-word store then load; byte-lane merge
    doReq(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0, 1'b0);
    doReq(1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    doReq(1'b1, 32'h10, 32'h0000AA00, 4'b0010, 1'b0, 1'b0, 1'b0);
    doReq(1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    waitIdle();

    // Stalled response with a new request held behind it
    readyVal = 1'b0;
    @(negedge clk);
    doReq(1'b0, 32'h10, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0);
    req_write = 1'b1;
    req_addr  = 32'h14;
    req_wdata = 32'h01020304;
    req_wstrb = 4'b1111;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    readyVal = 1'b1;
    doReq(1'b1, 32'h14, 32'h01020304, 4'b1111, 1'b0, 1'b0, 1'b1);

    // Misaligned and out-of-range accesses
    doReq(1'b1, 32'h12, 32'hFFFFFFFF, 4'b1111, 1'b0, 1'b0, 1'b0);
    doReq(1'b0, 32'h400, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    doReq(1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Reset while a store waits: the store must not land
    doReq(1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, 1'b0, 1'b0, 1'b0);
    doReq(1'b0, 32'h20, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    waitIdle();
    doReq(1'b1, 32'h20, 32'h12345678, 4'b1111, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("midop_reset_req_ready", 32'(req_ready), 32'd0);
    check("midop_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("after_reset_req_ready", 32'(req_ready), 32'd1);
    check("after_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    doReq(1'b0, 32'h20, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    waitIdle();

    // Back-to-back loads with req_valid and rsp_ready held high
    acceptLog.delete();
    doReq(1'b0, 32'h10, 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);
    doReq(1'b0, 32'h14, 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);
    doReq(1'b0, 32'h20, 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);
    doReq(1'b0, 32'h24, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    if (acceptLog.size() == 4) begin
      for (int i = 0; i < 3; i++)
        check("accept_period", acceptLog[i+1] - acceptLog[i], LAT + 2);
    end else begin
      checks++;
      failures++;
      $display("FAIL accept_count: got %0d required 4", acceptLog.size());
    end
    waitIdle();

    // Initialise a known region, then randomized traffic with random back-pressure
    for (int w = 0; w < 16; w++)
      doReq(1'b1, 32'(w * 4), $urandom, 4'b1111, 1'b0, 1'b0, 1'b0);
    waitIdle();
    readyMode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      int unsigned k;
      logic [31:0] a;
      bit          keepBit;
      k = $urandom_range(0, 9);
      if (k == 0)      a = $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
      else if (k == 1) a = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFC : (DEPTH + $urandom_range(0, 15)) * 4;
      else             a = $urandom_range(0, 15) * 4;
      keepBit = (i < 59) ? 1'($urandom_range(0, 1)) : 1'b0;
      doReq(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), keepBit, 1'b0, 1'b0);
      if (!keepBit && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    waitIdle();
    readyMode = 1'b0;
    repeat (4) @(negedge clk);
    check("queue_empty", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
